// File: rtl/operand_loader_if.sv
// Purpose  : bundles the word-stream input and the operand-set output of operand_loader.
// Latency  : n/a (wiring only).
// Backpressure: carries in_valid/in_ready on the input side and out_valid/out_ready on the output side.
//
// Signals:
//   in_data/in_valid/in_ready : W-bit word stream into the loader
//   op_in                     : opcode, sampled with the last B word
//   out_operands              : {B, A}, A in the low n bits
//   out_op/out_valid/out_ready: captured opcode and operand-set handshake
// Modports: master = producer/consumer side (drives words, takes sets), slave = loader.
interface operand_loader_if #(
    parameter int n = 256,
    parameter int W = 8
);
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op_in;
    logic [2*n-1:0] out_operands;
    logic [2:0]     out_op;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data,
        output in_valid,
        output op_in,
        output out_ready,
        input  in_ready,
        input  out_operands,
        input  out_op,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  op_in,
        input  out_ready,
        output in_ready,
        output out_operands,
        output out_op,
        output out_valid
    );
endinterface

// File: rtl/operand_loader.sv
// Purpose  : assembles two n-bit operands and a 3-bit opcode from a W-bit word stream for the ALU input register.
// Latency  : last B word accepted at edge t -> out_valid high in the cycle after t; one set per 2K+1 cycles at best.
// Backpressure: in_ready drops while a complete set is held; the set stays frozen until an edge with out_ready=1.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (state, storage and outputs to zero)
//   clear : synchronous flush back to LOAD_A; storage untouched, same-edge word dropped
//   bus   : operand_loader_if.slave (word stream in, {B,A}/opcode out)
module operand_loader #(
    parameter int n = 256,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    operand_loader_if.slave      bus
);

    // Words per operand and the counter that walks through them.
    localparam int K  = n / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic           valid_q;
    logic           valid_nxt;

    // Datapath write strobes produced by the FSM.
    logic           wr_a;
    logic           wr_b;
    logic           cap_op;

    logic [n-1:0]   a_q;
    logic [n-1:0]   b_q;
    logic [2:0]     op_q;

    logic           accept;
    logic           last_word;

    // Ready is purely a function of state: the loader only refuses words while a set is held.
    assign bus.in_ready = (state != HOLD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_word    = (cnt == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD_A;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            valid_q <= valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and write-strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = valid_q;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        cap_op    = 1'b0;

        if (clear) begin
            // Flush wins over any accept on the same edge; no strobes fire.
            state_nxt = LOAD_A;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (accept) begin
                        wr_a = 1'b1;
                        if (last_word) begin
                            cnt_nxt   = '0;
                            state_nxt = LOAD_B;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        wr_b = 1'b1;
                        if (last_word) begin
                            cnt_nxt   = '0;
                            cap_op    = 1'b1;
                            state_nxt = HOLD;
                            valid_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // in_ready is low here, so the exit edge can never also take a word.
                    if (bus.out_ready) begin
                        state_nxt = LOAD_A;
                        cnt_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = LOAD_A;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand and opcode storage. Never cleared between sets: every word
    // slot is rewritten before the next out_valid, so stale bytes cannot
    // show up under a valid set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            for (int k = 0; k < K; k++) begin
                if (wr_a && (cnt == CW'(k))) begin
                    a_q[k*W +: W] <= bus.in_data;
                end
                if (wr_b && (cnt == CW'(k))) begin
                    b_q[k*W +: W] <= bus.in_data;
                end
            end
            if (cap_op) begin
                op_q <= bus.op_in;
            end
        end
    end

    // Partial words are visible during LOAD; out_valid qualifies the bus.
    assign bus.out_operands = {b_q, a_q};
    assign bus.out_op       = op_q;
    assign bus.out_valid    = valid_q;

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the registered ALU datapath (input register → ALU → output register).
- Assembles the two n-bit operands (A, B) and the 3-bit opcode from a narrow W-bit word stream using a valid/ready handshake.
- Presents the packed 2n-bit operand bus and opcode, held stable with a valid flag, to the ALU input register.
- Frees the ALU from needing a 2n-bit-wide source.

Parameters:
- n, 256, operand width in bits; matches the ALU width.
- W, 8, input word width in bits; n must be an exact multiple of W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush to LOAD_A; discards any partial or held operands
- in_data  input  W  operand word
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts in_data this cycle
- op_in  input  3  opcode; sampled with the last B word
- out_operands  output  2n  {B, A}: A in [n-1:0], B in [2n-1:n]; feeds the ALU input register
- out_op  output  3  captured opcode
- out_valid  output  1  out_operands/out_op complete and stable
- out_ready  input  1  consumer takes the current operand set

Behaviour:
- Word transfer: a word is accepted on a clock edge where in_valid && in_ready.
- Words per operand: K = n/W. Word counter width is clog2(K); minimum 1.
- State LOAD_A (reset state):
  - in_ready=1.
  - Accepted word i (i = 0..K-1) is written to A[i*W +: W], least-significant word first.
  - After word K-1, counter returns to 0 and the state goes to LOAD_B.
- State LOAD_B:
  - in_ready=1.
  - Same fill rule into B.
  - With word K-1, op_in is captured into out_op, the state goes to HOLD, and out_valid=1 from the next cycle.
- State HOLD:
  - in_ready=0; out_valid=1.
  - out_operands and out_op are frozen.
  - The edge with out_ready=1 completes the transfer: out_valid=0 next cycle, state goes to LOAD_A, counter=0.
  - No word is accepted on the same edge as the HOLD exit; in_ready rises one cycle later.
- out_valid is registered and is 1 only in HOLD.
- Partial operand words are visible on out_operands during LOAD; consumers qualify with out_valid.
- Operand storage is not cleared between sets. Each word is overwritten before the next out_valid, so stale data never appears under out_valid.
- clear:
  - Has priority over everything except rst_n.
  - State goes to LOAD_A, counter=0, out_valid=0.
  - Storage is left unchanged.
  - A word presented on the same edge is dropped.
- Reset (rst_n=0, asynchronous, at any time including mid-load or in HOLD):
  - State LOAD_A, counter=0.
  - out_operands=0, out_op=0, out_valid=0.
  - in_ready=1 once rst_n deasserts.
- in_valid=0 stalls the fill indefinitely; counter and contents hold.
- out_ready is ignored outside HOLD.
- Latency: last B word accepted at edge t → out_valid=1 in the cycle after t.
- Throughput: one operand set per 2K+1 cycles minimum (2K words plus one HOLD cycle).

Test Plan:
- Basic load (n=16, W=8, K=2):
  - Stimulus: words 0x34, 0x12, 0x78, 0x56 back-to-back; op_in=3 on the last word; out_ready=1.
  - Required: out_operands=0x5678_1234 and out_op=3 with out_valid=1 for exactly one cycle; in_ready=0 in that cycle; in_ready=1 the following cycle.
- Backpressure (n=16, W=8):
  - Stimulus: complete a set; hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=0xFF.
  - Required: out_valid stays 1; out_operands unchanged; no 0xFF word absorbed. When out_ready rises, the next 4 words form the next set.
- Gaps:
  - Stimulus: insert in_valid=0 bubbles between every word.
  - Required: same result as the basic load; the counter advances only on accepted words.
- Clear mid-operand:
  - Stimulus: after 3 words (A done, one B word), pulse clear; then send a fresh 0x01, 0x00, 0x02, 0x00 with op_in=5.
  - Required: out_operands=0x0002_0001, out_op=5.
- Async reset in HOLD:
  - Stimulus: drop rst_n between clock edges while out_valid=1.
  - Required: out_valid, out_operands and out_op go to 0 immediately (before the next edge); after release, a normal load succeeds.
- Default size (n=256, W=8):
  - Stimulus: words 0..63 (value = index) with op_in=7.
  - Required: A byte i = i, B byte i = 32+i, out_op=7; out_valid asserts after exactly 64 accepted words.
